// File: rtl/qoi_enc_stream_if.sv
// Pixel-in / byte-out stream bundle for the QOI encoder.
// Both sides follow valid/ready: a beat moves on a rising clk edge where valid && ready; the
// source holds data steady while valid && !ready and never withdraws valid before the beat completes.
interface qoi_enc_stream_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/qoi_enc_stream.sv
// Streaming QOI image encoder: takes one pixel at a time and emits the encoded byte stream,
// optionally followed by the 8-byte end marker.
module qoi_enc_stream #(
  parameter int CHANNELS = 4,
  parameter int MAX_RUN  = 62,
  parameter int EMIT_END = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     npix,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state,
  qoi_enc_stream_if.slave bus
);
  if (CHANNELS != 3 && CHANNELS != 4) begin : g_bad_channels
    $error("qoi_enc_stream: CHANNELS must be 3 or 4");
  end
  if (MAX_RUN < 1 || MAX_RUN > 62) begin : g_bad_max_run
    $error("qoi_enc_stream: MAX_RUN must be in 1..62");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_CLASSIFY = 3'd2, S_EMIT = 3'd3, S_END = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_px, r_prev, r_npix, r_cnt;
  logic [5:0]  r_run;
  logic [31:0] r_idx [64];
  logic [63:0] r_idx_vld;
  logic [7:0]  r_buf [8];
  logic [2:0]  r_len, r_pos;
  logic        r_done;

  logic [7:0]        w_r, w_g, w_b, w_a;
  logic [5:0]        w_hash;
  logic [31:0]       w_entry;
  logic signed [7:0] w_vr, w_vg, w_vb;
  logic signed [8:0] w_vg_r, w_vg_b;
  logic [6:0]        w_run_inc;
  logic              w_eq, w_last, w_run_full, w_a_same, w_idx_hit, w_diff_ok, w_luma_ok;
  logic              w_chunk_end;
  logic [7:0]        w_chk [5];
  logic [2:0]        w_chk_len;
  logic [7:0]        w_buf [8];
  logic [2:0]        w_len;

  assign w_r = r_px[7:0];
  assign w_g = r_px[15:8];
  assign w_b = r_px[23:16];
  assign w_a = r_px[31:24];
  assign w_hash = 6'(13'(w_r) * 13'd3 + 13'(w_g) * 13'd5 + 13'(w_b) * 13'd7 + 13'(w_a) * 13'd11);
  // Entries never written since start read as transparent black.
  assign w_entry = r_idx_vld[w_hash] ? r_idx[w_hash] : 32'h0;

  assign w_vr   = w_r - r_prev[7:0];
  assign w_vg   = w_g - r_prev[15:8];
  assign w_vb   = w_b - r_prev[23:16];
  assign w_vg_r = {w_vr[7], w_vr} - {w_vg[7], w_vg};
  assign w_vg_b = {w_vb[7], w_vb} - {w_vg[7], w_vg};

  assign w_eq        = (r_px == r_prev);
  assign w_last      = (r_cnt == r_npix);
  assign w_run_inc   = {1'b0, r_run} + 7'd1;
  assign w_run_full  = (w_run_inc == 7'(MAX_RUN));
  assign w_a_same    = (w_a == r_prev[31:24]);
  assign w_idx_hit   = (w_entry == r_px);
  assign w_diff_ok   = w_a_same && (w_vr >= -8'sd2) && (w_vr <= 8'sd1) && (w_vg >= -8'sd2) &&
                       (w_vg <= 8'sd1) && (w_vb >= -8'sd2) && (w_vb <= 8'sd1);
  assign w_luma_ok   = w_a_same && (w_vg >= -8'sd32) && (w_vg <= 8'sd31) && (w_vg_r >= -9'sd8) &&
                       (w_vg_r <= 9'sd7) && (w_vg_b >= -9'sd8) && (w_vg_b <= 9'sd7);
  assign w_chunk_end = (r_pos == r_len - 3'd1);

  always_comb begin
    for (int i = 0; i < 5; i++) w_chk[i] = 8'h00;
    w_chk_len = 3'd1;
    if (w_idx_hit) begin
      w_chk[0] = {2'b00, w_hash};
    end else if (w_diff_ok) begin
      w_chk[0] = {2'b01, 2'(w_vr + 8'sd2), 2'(w_vg + 8'sd2), 2'(w_vb + 8'sd2)};
    end else if (w_luma_ok) begin
      w_chk[0]  = {2'b10, 6'(w_vg + 8'sd32)};
      w_chk[1]  = {4'(w_vg_r + 9'sd8), 4'(w_vg_b + 9'sd8)};
      w_chk_len = 3'd2;
    end else if (w_a_same) begin
      w_chk[0]  = 8'hFE;
      w_chk[1]  = w_r;
      w_chk[2]  = w_g;
      w_chk[3]  = w_b;
      w_chk_len = 3'd4;
    end else begin
      w_chk[0]  = 8'hFF;
      w_chk[1]  = w_r;
      w_chk[2]  = w_g;
      w_chk[3]  = w_b;
      w_chk[4]  = w_a;
      w_chk_len = 3'd5;
    end
  end

  // A pending run is flushed ahead of the pixel chunk in the same burst so bytes stay back to back.
  always_comb begin
    for (int i = 0; i < 8; i++) w_buf[i] = 8'h00;
    w_len = 3'd0;
    if (w_eq) begin
      w_buf[0] = {2'b11, r_run};
      w_len    = 3'd1;
    end else if (r_run != 6'd0) begin
      w_buf[0] = {2'b11, r_run - 6'd1};
      for (int i = 0; i < 5; i++) w_buf[i + 1] = w_chk[i];
      w_len = w_chk_len + 3'd1;
    end else begin
      for (int i = 0; i < 5; i++) w_buf[i] = w_chk[i];
      w_len = w_chk_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = (npix == 32'd0) ? S_END : S_FETCH;
      S_FETCH:    if (bus.pix_valid) w_next = S_CLASSIFY;
      S_CLASSIFY: w_next = (w_eq && !w_run_full && !w_last) ? S_FETCH : S_EMIT;
      S_EMIT: begin
        if (bus.out_ready && w_chunk_end) begin
          if (!w_last)            w_next = S_FETCH;
          else if (EMIT_END != 0) w_next = S_END;
          else                    w_next = S_IDLE;
        end
      end
      S_END:      if (EMIT_END == 0 || (bus.out_ready && r_pos == 3'd7)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready = (r_state == S_FETCH);
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_last  = 1'b0;
    case (r_state)
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_buf[r_pos];
        bus.out_last  = (EMIT_END == 0) && w_last && w_chunk_end;
      end
      S_END: begin
        bus.out_valid = (EMIT_END != 0);
        bus.out_data  = (EMIT_END != 0) ? {7'd0, r_pos == 3'd7} : 8'h00;
        bus.out_last  = (EMIT_END != 0) && (r_pos == 3'd7);
      end
      default: ;
    endcase
    busy      = (r_state != S_IDLE);
    done      = r_done;
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px      <= 32'h0;
      r_prev    <= 32'h0;
      r_npix    <= 32'h0;
      r_cnt     <= 32'h0;
      r_run     <= 6'd0;
      r_idx_vld <= 64'h0;
      r_len     <= 3'd0;
      r_pos     <= 3'd0;
      r_done    <= 1'b0;
      for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_npix    <= npix;
            r_prev    <= 32'hFF00_0000;
            r_run     <= 6'd0;
            r_cnt     <= 32'h0;
            r_idx_vld <= 64'h0;
            r_pos     <= 3'd0;
          end
        end
        S_FETCH: begin
          if (bus.pix_valid) begin
            r_px  <= (CHANNELS == 3) ? {8'hFF, bus.pix_data[23:0]} : bus.pix_data;
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CLASSIFY: begin
          r_buf <= w_buf;
          r_len <= w_len;
          r_pos <= 3'd0;
          if (w_eq) begin
            r_run <= (w_run_full || w_last) ? 6'd0 : w_run_inc[5:0];
          end else begin
            r_run             <= 6'd0;
            r_idx_vld[w_hash] <= 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            if (w_chunk_end) begin
              r_prev <= r_px;
              r_pos  <= 3'd0;
              if (w_last && EMIT_END == 0) r_done <= 1'b1;
            end else begin
              r_pos <= r_pos + 3'd1;
            end
          end
        end
        S_END: begin
          if (EMIT_END == 0) begin
            r_done <= 1'b1;
          end else if (bus.out_ready) begin
            if (r_pos == 3'd7) r_done <= 1'b1;
            else               r_pos  <= r_pos + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Index payload needs no reset: the valid bits decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_CLASSIFY && !w_eq) r_idx[w_hash] <= r_px;
  end
endmodule
